// File: rtl/minefield_revealer.sv
// Tracks revealed minesweeper cells and floods zero regions with a repeated raster sweep.
// Define MINEFIELD_REVEALER_FLAGS_EN to add per-cell flags that block opening.
module minefield_revealer #(
  parameter int unsigned MAX_CELL_WIDTH  = 30,
  parameter int unsigned MAX_CELL_HEIGHT = 16,
  localparam int unsigned CELL_COUNT           = MAX_CELL_WIDTH * MAX_CELL_HEIGHT,
  localparam int unsigned MINES_COUNT_FF_WIDTH = $clog2(CELL_COUNT / 4),
  localparam int unsigned CELL_X_WIDTH         = $clog2(MAX_CELL_WIDTH),
  localparam int unsigned CELL_Y_WIDTH         = $clog2(MAX_CELL_HEIGHT),
  localparam int unsigned CNT_WIDTH            = $clog2(CELL_COUNT + 1)
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0][3:0] game_field_i,
  input  logic [CELL_X_WIDTH-1:0]                             field_width_i,
  input  logic [CELL_Y_WIDTH-1:0]                             field_height_i,
  input  logic [MINES_COUNT_FF_WIDTH-1:0]                     mines_count_i,
  input  logic                                                new_game_i,
  input  logic                                                open_valid_i,
  input  logic [CELL_X_WIDTH-1:0]                             open_x_i,
  input  logic [CELL_Y_WIDTH-1:0]                             open_y_i,
`ifdef MINEFIELD_REVEALER_FLAGS_EN
  input  logic                                                flag_valid_i,
  input  logic [CELL_X_WIDTH-1:0]                             flag_x_i,
  input  logic [CELL_Y_WIDTH-1:0]                             flag_y_i,
  output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0]      flagged_o,
`endif
  output logic                                                open_ready_o,
  output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0]      revealed_o,
  output logic [CNT_WIDTH-1:0]                                revealed_count_o,
  output logic                                                busy_o,
  output logic                                                done_o,
  output logic                                                game_over_o,
  output logic                                                game_won_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StSweep = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned XExtW = CELL_X_WIDTH + 1;
  localparam int unsigned YExtW = CELL_Y_WIDTH + 1;
  localparam int unsigned WinW  = CNT_WIDTH + 1;
  localparam logic [XExtW-1:0]     MaxXExt = XExtW'(MAX_CELL_WIDTH);
  localparam logic [YExtW-1:0]     MaxYExt = YExtW'(MAX_CELL_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] CntMax  = CNT_WIDTH'(CELL_COUNT);
  localparam logic [3:0]           MineVal = 4'd9;

  typedef logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0] grid_t;

  logic [1:0]                      state_q, state_d;
  logic [CELL_X_WIDTH-1:0]         width_q, width_d, x_q, x_d;
  logic [CELL_Y_WIDTH-1:0]         height_q, height_d, y_q, y_d;
  logic [MINES_COUNT_FF_WIDTH-1:0] mines_q, mines_d;
  grid_t                           revealed_q, revealed_d;
  logic [CNT_WIDTH-1:0]            count_q, count_d, count_inc;
  logic                            over_q, over_d, won_q, won_d, changed_q, changed_d;

  logic [XExtW-1:0] lim_x, nx;
  logic [YExtW-1:0] lim_y, ny;
  logic             zero_nb, open_play, open_flag, cur_flag, accept_open, sweep_reveal;
  logic             last_x, last_y, win_hit;
  logic [3:0]       cur_val;
  logic [WinW-1:0]  area, mines_ext;

  function automatic logic in_play(input logic [CELL_X_WIDTH-1:0] x,
                                   input logic [CELL_Y_WIDTH-1:0] y,
                                   input logic [XExtW-1:0] lx, input logic [YExtW-1:0] ly);
    return (x != '0) && ({1'b0, x} < lx) && (y != '0) && ({1'b0, y} < ly);
  endfunction

  // Latched dimensions larger than the array are clipped to the physical array.
  assign lim_x = ({1'b0, width_q} > MaxXExt) ? MaxXExt : {1'b0, width_q};
  assign lim_y = ({1'b0, height_q} > MaxYExt) ? MaxYExt : {1'b0, height_q};

  assign open_ready_o = rst && (state_q == StIdle) && !over_q && !won_q;
  assign accept_open  = open_valid_i && open_ready_o && !new_game_i;
  assign open_play    = in_play(open_x_i, open_y_i, lim_x, lim_y);
  assign cur_val      = game_field_i[x_q][y_q];
  assign count_inc    = (count_q == CntMax) ? count_q : count_q + CNT_WIDTH'(1);
  assign last_x       = ({1'b0, x_q} == lim_x - XExtW'(1));
  assign last_y       = ({1'b0, y_q} == lim_y - YExtW'(1));

  assign area      = WinW'(width_q - CELL_X_WIDTH'(1)) * WinW'(height_q - CELL_Y_WIDTH'(1));
  assign mines_ext = WinW'(mines_q);
  assign win_hit   = !over_q && (area >= mines_ext) && ({1'b0, count_q} == area - mines_ext);

`ifdef MINEFIELD_REVEALER_FLAGS_EN
  grid_t flagged_q, flagged_d;
  logic  accept_flag;
  assign accept_flag = flag_valid_i && open_ready_o && !new_game_i && !open_valid_i;
  assign open_flag   = flagged_q[open_x_i][open_y_i];
  assign cur_flag    = flagged_q[x_q][y_q];
  assign flagged_o   = flagged_q;
`else
  assign open_flag = 1'b0;
  assign cur_flag  = 1'b0;
`endif

  // Any of the 8 neighbours already revealed with value 0.
  always_comb begin
    zero_nb = 1'b0;
    nx      = '0;
    ny      = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        nx = {1'b0, x_q} + XExtW'(i) - XExtW'(1);
        ny = {1'b0, y_q} + YExtW'(j) - YExtW'(1);
        if (!(i == 1 && j == 1) && (nx < MaxXExt) && (ny < MaxYExt)) begin
          if (revealed_q[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]] &&
              (game_field_i[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]] == 4'd0)) begin
            zero_nb = 1'b1;
          end
        end
      end
    end
  end

  assign sweep_reveal = !revealed_q[x_q][y_q] && (cur_val != MineVal) && zero_nb && !cur_flag;

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    mines_d    = mines_q;
    x_d        = x_q;
    y_d        = y_q;
    revealed_d = revealed_q;
    count_d    = count_q;
    over_d     = over_q;
    won_d      = won_q;
    changed_d  = changed_q;
`ifdef MINEFIELD_REVEALER_FLAGS_EN
    flagged_d  = flagged_q;
`endif
    if (new_game_i) begin
      state_d    = StIdle;
      width_d    = field_width_i;
      height_d   = field_height_i;
      mines_d    = mines_count_i;
      revealed_d = '0;
      count_d    = '0;
      over_d     = 1'b0;
      won_d      = 1'b0;
      changed_d  = 1'b0;
`ifdef MINEFIELD_REVEALER_FLAGS_EN
      flagged_d  = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept_open) begin
            x_d     = open_x_i;
            y_d     = open_y_i;
            state_d = (open_play && !revealed_q[open_x_i][open_y_i] && !open_flag) ?
                      StCheck : StDone;
          end
`ifdef MINEFIELD_REVEALER_FLAGS_EN
          else if (accept_flag && in_play(flag_x_i, flag_y_i, lim_x, lim_y) &&
                   !revealed_q[flag_x_i][flag_y_i]) begin
            flagged_d[flag_x_i][flag_y_i] = !flagged_q[flag_x_i][flag_y_i];
          end
`endif
        end
        StCheck: begin
          revealed_d[x_q][y_q] = 1'b1;
          count_d              = count_inc;
          if (cur_val == MineVal) begin
            over_d  = 1'b1;
            state_d = StDone;
          end else if (cur_val == 4'd0) begin
            x_d       = CELL_X_WIDTH'(1);
            y_d       = CELL_Y_WIDTH'(1);
            changed_d = 1'b0;
            state_d   = StSweep;
          end else begin
            state_d = StDone;
          end
        end
        StSweep: begin
          if (sweep_reveal) begin
            revealed_d[x_q][y_q] = 1'b1;
            count_d              = count_inc;
          end
          changed_d = changed_q || sweep_reveal;
          if (!last_x) begin
            x_d = x_q + CELL_X_WIDTH'(1);
          end else begin
            x_d = CELL_X_WIDTH'(1);
            if (!last_y) begin
              y_d = y_q + CELL_Y_WIDTH'(1);
            end else begin
              y_d       = CELL_Y_WIDTH'(1);
              changed_d = 1'b0;
              if (!(changed_q || sweep_reveal)) state_d = StDone;
            end
          end
        end
        StDone: begin
          if (win_hit) won_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      mines_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      revealed_q <= '0;
      count_q    <= '0;
      over_q     <= 1'b0;
      won_q      <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      mines_q    <= mines_d;
      x_q        <= x_d;
      y_q        <= y_d;
      revealed_q <= revealed_d;
      count_q    <= count_d;
      over_q     <= over_d;
      won_q      <= won_d;
      changed_q  <= changed_d;
    end
  end

`ifdef MINEFIELD_REVEALER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst) flagged_q <= '0;
    else      flagged_q <= flagged_d;
  end
`endif

  assign revealed_o       = revealed_q;
  assign revealed_count_o = count_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = rst && (state_q == StDone) && !new_game_i;
  assign game_over_o      = over_q;
  assign game_won_o       = won_q;

endmodule

// File: tb/tb_minefield_revealer.sv
// Self-checking bench for minefield_revealer: directed vector table, corner sequences and
// randomized games checked against a queue-based flood-fill model.
module tb_minefield_revealer;

  localparam int MW = 30;
  localparam int MH = 16;

  typedef logic [MW-1:0][MH-1:0] grid_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [MW-1:0][MH-1:0][3:0] game_field_i;
  logic [4:0]             field_width_i;
  logic [3:0]             field_height_i;
  logic [6:0]             mines_count_i;
  logic                   new_game_i, open_valid_i;
  logic [4:0]             open_x_i;
  logic [3:0]             open_y_i;
  logic                   open_ready_o, busy_o, done_o, game_over_o, game_won_o;
  grid_t                  revealed_o;
  logic [8:0]             revealed_count_o;
`ifdef MINEFIELD_REVEALER_FLAGS_EN
  logic                   flag_valid_i;
  logic [4:0]             flag_x_i;
  logic [3:0]             flag_y_i;
  grid_t                  flagged_o;
`endif

  minefield_revealer dut (
    .clk              (clk),
    .rst              (rst),
    .game_field_i     (game_field_i),
    .field_width_i    (field_width_i),
    .field_height_i   (field_height_i),
    .mines_count_i    (mines_count_i),
    .new_game_i       (new_game_i),
    .open_valid_i     (open_valid_i),
    .open_x_i         (open_x_i),
    .open_y_i         (open_y_i),
`ifdef MINEFIELD_REVEALER_FLAGS_EN
    .flag_valid_i     (flag_valid_i),
    .flag_x_i         (flag_x_i),
    .flag_y_i         (flag_y_i),
    .flagged_o        (flagged_o),
`endif
    .open_ready_o     (open_ready_o),
    .revealed_o       (revealed_o),
    .revealed_count_o (revealed_count_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .game_over_o      (game_over_o),
    .game_won_o       (game_won_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int mval[MW][MH];
  bit mrev[MW][MH];
  int mW, mH, mM, mcnt;
  bit mover, mwon;

  typedef struct {
    int x; int y; int lat; int cnt; int over; int won; int bit_exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_grid(input string name, input grid_t act, input grid_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_play(int x, int y);
    return x >= 1 && x < mW && y >= 1 && y < mH;
  endfunction

  function automatic grid_t m_grid();
    grid_t g = '0;
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) g[x][y] = mrev[x][y];
    return g;
  endfunction

  task automatic m_done();
    int area;
    area = (mW - 1) * (mH - 1);
    if (!mover && area >= mM && mcnt == area - mM) mwon = 1;
  endtask

  // Closure: every safe playable cell touching a revealed zero becomes revealed.
  task automatic m_flood();
    int qx[$];
    int qy[$];
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++)
        if (mrev[x][y] && mval[x][y] == 0) begin qx.push_back(x); qy.push_back(y); end
    while (qx.size() > 0) begin
      int cx, cy;
      cx = qx.pop_front();
      cy = qy.pop_front();
      for (int dx = -1; dx <= 1; dx++)
        for (int dy = -1; dy <= 1; dy++)
          if (m_play(cx + dx, cy + dy) && !mrev[cx + dx][cy + dy] &&
              mval[cx + dx][cy + dy] != 9) begin
            mrev[cx + dx][cy + dy] = 1;
            mcnt++;
            if (mval[cx + dx][cy + dy] == 0) begin
              qx.push_back(cx + dx);
              qy.push_back(cy + dy);
            end
          end
    end
  endtask

  // kind: 0 not accepted, 1 straight to done, 2 single reveal, 3 flood
  task automatic m_open(input int x, input int y, output int kind);
    if (mover || mwon) begin kind = 0; return; end
    if (!m_play(x, y) || mrev[x][y]) begin m_done(); kind = 1; return; end
    mrev[x][y] = 1;
    mcnt++;
    if (mval[x][y] == 9) mover = 1;
    if (mval[x][y] == 0) begin m_flood(); kind = 3; end
    else kind = 2;
    m_done();
  endtask

  task automatic load_field();
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) game_field_i[x][y] = 4'(mval[x][y]);
  endtask

  task automatic fill_const(input int v);
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) mval[x][y] = v;
  endtask

  task automatic start_game(input int w, input int h, input int m);
    load_field();
    field_width_i  = 5'(w);
    field_height_i = 4'(h);
    mines_count_i  = 7'(m);
    new_game_i     = 1;
    @(posedge clk); #1;
    new_game_i = 0;
    mW = w; mH = h; mM = m; mcnt = 0; mover = 0; mwon = 0;
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) mrev[x][y] = 0;
  endtask

  // Returns cycles from the accepting cycle to done_o, 0 if none within budget.
  task automatic do_open(input int x, input int y, input int budget, output int lat);
    open_x_i     = 5'(x);
    open_y_i     = 4'(y);
    open_valid_i = 1;
    @(posedge clk); #1;
    open_valid_i = 0;
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (done_o) begin lat = c; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_state(input string tag);
    chk_grid({tag, " revealed"}, revealed_o, m_grid());
    chk({tag, " count"}, revealed_count_o, mcnt);
    chk({tag, " over"}, game_over_o, mover);
    chk({tag, " won"}, game_won_o, mwon);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, kind, seen, p;
    rst = 0; new_game_i = 0; open_valid_i = 0; open_x_i = 0; open_y_i = 0;
    field_width_i = 0; field_height_i = 0; mines_count_i = 0;
    fill_const(0); load_field();
`ifdef MINEFIELD_REVEALER_FLAGS_EN
    flag_valid_i = 0; flag_x_i = 0; flag_y_i = 0;
`endif

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk_grid("rst revealed", revealed_o, '0);
    chk("rst count", revealed_count_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst over", game_over_o, 0);
    chk("rst won", game_won_o, 0);
    chk("rst ready", open_ready_o, 0);
    rst = 1;
    #1;
    chk("post-rst ready", open_ready_o, 1);

    // Directed table on a numbered 5x5 field with a mine at (3,3)
    tbl[0] = '{2, 2, 2, 1, 0, 0, 1};
    tbl[1] = '{2, 2, 1, 1, 0, 0, 1};
    tbl[2] = '{0, 2, 1, 1, 0, 0, 0};
    tbl[3] = '{4, 1, 2, 2, 0, 0, 1};
    tbl[4] = '{3, 3, 2, 3, 1, 0, 1};
    tbl[5] = '{1, 1, 0, 3, 1, 0, 0};
    fill_const(1);
    mval[3][3] = 9;
    start_game(5, 5, 1);
    for (int i = 0; i < 6; i++) begin
      do_open(tbl[i].x, tbl[i].y, (tbl[i].lat == 0) ? 6 : 50, lat);
      m_open(tbl[i].x, tbl[i].y, kind);
      chk($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d count", i), revealed_count_o, tbl[i].cnt);
      chk($sformatf("tbl%0d over", i), game_over_o, tbl[i].over);
      chk($sformatf("tbl%0d won", i), game_won_o, tbl[i].won);
      chk($sformatf("tbl%0d cell", i), revealed_o[tbl[i].x][tbl[i].y], tbl[i].bit_exp);
      chk_grid($sformatf("tbl%0d grid", i), revealed_o, m_grid());
    end
    chk("ready after mine", open_ready_o, 0);

    // All-zero 5x5: two passes of 16 cells
    fill_const(0);
    start_game(5, 5, 0);
    do_open(1, 1, 200, lat);
    m_open(1, 1, kind);
    chk("zero5 latency", lat, 34);
    chk("zero5 count", revealed_count_o, 16);
    chk("zero5 won", game_won_o, 1);
    chk("zero5 ready", open_ready_o, 0);
    chk_state("zero5");

    // Mines exceed playable area: never a win
    start_game(3, 3, 5);
    do_open(1, 1, 100, lat);
    m_open(1, 1, kind);
    chk("overmine latency", lat, 10);
    chk("overmine count", revealed_count_o, 4);
    chk("overmine won", game_won_o, 0);
    chk("overmine ready", open_ready_o, 1);

    // new_game in mid-sweep aborts without a done pulse
    start_game(5, 5, 0);
    open_x_i = 1; open_y_i = 1; open_valid_i = 1;
    @(posedge clk); #1;
    open_valid_i = 0;
    seen = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done_o) seen = 1;
      @(posedge clk); #1;
    end
    chk("abort busy mid-sweep", busy_o, 1);
    new_game_i = 1;
    @(negedge clk);
    if (done_o) seen = 1;
    @(posedge clk); #1;
    new_game_i = 0;
    chk("abort busy", busy_o, 0);
    chk("abort count", revealed_count_o, 0);
    chk_grid("abort grid", revealed_o, '0);
    chk("abort ready", open_ready_o, 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    chk("abort no done", seen, 0);
    @(posedge clk); #1;

`ifdef MINEFIELD_REVEALER_FLAGS_EN
    fill_const(1);
    start_game(5, 5, 0);
    flag_x_i = 3; flag_y_i = 3; flag_valid_i = 1;
    @(posedge clk); #1;
    flag_valid_i = 0;
    chk("flag set", flagged_o[3][3], 1);
    do_open(3, 3, 20, lat);
    chk("flag open latency", lat, 1);
    chk("flag open revealed", revealed_o[3][3], 0);
    chk("flag still set", flagged_o[3][3], 1);
    chk("flag count", revealed_count_o, 0);
`endif

    // Randomized games against the flood-fill model
    for (int g = 0; g < 6; g++) begin
      int w, h, m, x, y, r;
      w = $urandom_range(3, 10);
      h = $urandom_range(3, 10);
      m = 0;
      for (int cx = 0; cx < MW; cx++)
        for (int cy = 0; cy < MH; cy++) begin
          r = $urandom_range(0, 99);
          mval[cx][cy] = (r < 10) ? 9 : (r < 50) ? 0 : int'($urandom_range(1, 8));
        end
      mW = w; mH = h;
      for (int cx = 0; cx < MW; cx++)
        for (int cy = 0; cy < MH; cy++)
          if (m_play(cx, cy) && mval[cx][cy] == 9) m++;
      start_game(w, h, m);
      p = (w - 1) * (h - 1);
      for (int op = 0; op < 10; op++) begin
        x = $urandom_range(0, w);
        y = $urandom_range(0, h);
        chk($sformatf("g%0d op%0d ready", g, op), open_ready_o, !(mover || mwon));
        m_open(x, y, kind);
        do_open(x, y, (kind == 0) ? 6 : 4000, lat);
        if (kind == 3)
          chk($sformatf("g%0d op%0d flood latency %0d", g, op, lat),
              (lat > 2) && ((lat - 2) % p == 0), 1);
        else
          chk($sformatf("g%0d op%0d latency", g, op), lat, (kind == 0) ? 0 : kind);
        chk_state($sformatf("g%0d op%0d", g, op));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
